// File: rtl/table_pkg.sv
// Shared table geometry, coordinate type and player FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package table_pkg;

  localparam int TABLE_X_MIN = 44;
  localparam int TABLE_X_MAX = 979;
  localparam int TABLE_Y_MIN = 44;
  localparam int TABLE_Y_MAX = 735;
  localparam int CENTRE_X    = 511;

  typedef logic [11:0] coord_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    TRACK = 2'd1,
    REST  = 2'd2
  } player_state_t;

endpackage

// File: rtl/player_axis_step.sv
// One paddle axis: clamps a mouse sample into range and computes one rate-limited step toward target.
// Latency: purely combinational.
// Backpressure: none.
module player_axis_step
  import table_pkg::*;
#(
  parameter int LO       = 64,
  parameter int HI       = 491,
  parameter int MAX_STEP = 4
) (
  input  coord_t raw,
  input  coord_t pos,
  input  coord_t target,
  output coord_t clamped,
  output coord_t stepped
);

  localparam logic signed [12:0] LO_S   = 13'(LO);
  localparam logic signed [12:0] HI_S   = 13'(HI);
  localparam logic signed [12:0] STEP_S = 13'(MAX_STEP);

  logic signed [12:0] raw_s;
  logic signed [12:0] diff;
  logic signed [12:0] delta;

  // 13-bit signed so samples near 0 or 4095 cannot wrap past the limits
  always_comb begin
    raw_s = $signed({1'b0, raw});
    if (raw_s < LO_S)
      clamped = coord_t'(LO);
    else if (raw_s > HI_S)
      clamped = coord_t'(HI);
    else
      clamped = raw;

    diff = $signed({1'b0, target}) - $signed({1'b0, pos});
    if (diff > STEP_S)
      delta = STEP_S;
    else if (diff < -STEP_S)
      delta = -STEP_S;
    else
      delta = diff;

    stepped = coord_t'($signed({1'b0, pos}) + delta);
  end

endmodule

// File: rtl/draw_player_ctl.sv
// Player-1 paddle position: latches clamped mouse targets and steps toward them once per frame_tick.
// Latency: target usable the cycle after mouse_valid; position updates on the edge after frame_tick.
// Backpressure: none; strobes are always accepted. Optional PLAYER_VEL_OUT_EN adds velocity outputs.
module draw_player_ctl
  import table_pkg::*;
#(
  parameter int PLAYERS_RADIUS = 20,
  parameter int MAX_STEP       = 4,
  parameter int X_MIN          = TABLE_X_MIN,
  parameter int X_MAX          = CENTRE_X,
  parameter int Y_MIN          = TABLE_Y_MIN,
  parameter int Y_MAX          = TABLE_Y_MAX,
  parameter int HOME_X         = 150,
  parameter int HOME_Y         = 389
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic        mouse_valid,
  input  logic        frame_tick,
  output logic [11:0] xpos_player,
  output logic [11:0] ypos_player,
  output logic        moving
`ifdef PLAYER_VEL_OUT_EN
  ,
  output logic signed [4:0] xvel_player,
  output logic signed [4:0] yvel_player
`endif
);

  localparam coord_t HOME_XC = coord_t'(HOME_X);
  localparam coord_t HOME_YC = coord_t'(HOME_Y);

  player_state_t state;
  coord_t        tgt_x, tgt_y;
  coord_t        x_clamped, y_clamped;
  coord_t        x_stepped, y_stepped;
  coord_t        tgt_x_nxt, tgt_y_nxt;

  player_axis_step #(
    .LO       (X_MIN + PLAYERS_RADIUS),
    .HI       (X_MAX - PLAYERS_RADIUS),
    .MAX_STEP (MAX_STEP)
  ) u_axis_x (
    .raw     (xpos_mouse),
    .pos     (xpos_player),
    .target  (tgt_x),
    .clamped (x_clamped),
    .stepped (x_stepped)
  );

  player_axis_step #(
    .LO       (Y_MIN + PLAYERS_RADIUS),
    .HI       (Y_MAX - PLAYERS_RADIUS),
    .MAX_STEP (MAX_STEP)
  ) u_axis_y (
    .raw     (ypos_mouse),
    .pos     (ypos_player),
    .target  (tgt_y),
    .clamped (y_clamped),
    .stepped (y_stepped)
  );

  // A target arriving with the tick counts when deciding whether the step finished the move
  assign tgt_x_nxt = mouse_valid ? x_clamped : tgt_x;
  assign tgt_y_nxt = mouse_valid ? y_clamped : tgt_y;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT;
      xpos_player <= HOME_XC;
      ypos_player <= HOME_YC;
      tgt_x       <= HOME_XC;
      tgt_y       <= HOME_YC;
      moving      <= 1'b0;
    end else begin
      if (mouse_valid) begin
        tgt_x <= x_clamped;
        tgt_y <= y_clamped;
      end
      case (state)
        WAIT: begin
          if (mouse_valid) begin
            state  <= TRACK;
            moving <= 1'b1;
          end
        end
        TRACK: begin
          if (frame_tick) begin
            xpos_player <= x_stepped;
            ypos_player <= y_stepped;
            if (x_stepped == tgt_x_nxt && y_stepped == tgt_y_nxt) begin
              state  <= REST;
              moving <= 1'b0;
            end
          end
        end
        REST: begin
          if (mouse_valid && (x_clamped != xpos_player || y_clamped != ypos_player)) begin
            state  <= TRACK;
            moving <= 1'b1;
          end
        end
        default: begin
          state  <= WAIT;
          moving <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLAYER_VEL_OUT_EN
  // Steps never exceed MAX_STEP (<=15), so the low 5 bits of the difference are the signed step
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      xvel_player <= '0;
      yvel_player <= '0;
    end else if (frame_tick) begin
      if (state == TRACK) begin
        xvel_player <= 5'(x_stepped - xpos_player);
        yvel_player <= 5'(y_stepped - ypos_player);
      end else begin
        xvel_player <= '0;
        yvel_player <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_draw_player_ctl.sv
// Randomized and directed checks of draw_player_ctl against a behavioural paddle model.
module tb_draw_player_ctl;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [11:0] xpos_mouse = '0;
  logic [11:0] ypos_mouse = '0;
  logic        mouse_valid = 1'b0;
  logic        frame_tick  = 1'b0;
  logic [11:0] xpos_player, ypos_player;
  logic        moving;
`ifdef PLAYER_VEL_OUT_EN
  logic signed [4:0] xvel_player, yvel_player;
`endif

  int checks = 0;
  int errors = 0;

  // model: position, target, mode (0 idle-at-home, 1 tracking, 2 resting), last velocity
  int m_x, m_y, m_tx, m_ty, m_mode, m_vx, m_vy;

  always #5 clk_in = ~clk_in;

  draw_player_ctl dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .xpos_mouse  (xpos_mouse),
    .ypos_mouse  (ypos_mouse),
    .mouse_valid (mouse_valid),
    .frame_tick  (frame_tick),
    .xpos_player (xpos_player),
    .ypos_player (ypos_player),
    .moving      (moving)
`ifdef PLAYER_VEL_OUT_EN
    ,
    .xvel_player (xvel_player),
    .yvel_player (yvel_player)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int toward(input int p, input int t);
    int d;
    d = t - p;
    if (d > 4) d = 4;
    if (d < -4) d = -4;
    return p + d;
  endfunction

  task automatic model_reset;
    m_x = 150; m_y = 389; m_tx = 150; m_ty = 389;
    m_mode = 0; m_vx = 0; m_vy = 0;
  endtask

  task automatic compare;
    check("xpos", int'(xpos_player), m_x);
    check("ypos", int'(ypos_player), m_y);
    check("moving", int'(moving), (m_mode == 1) ? 1 : 0);
    check("x_range", (xpos_player >= 64 && xpos_player <= 491) ? 1 : 0, 1);
    check("y_range", (ypos_player >= 64 && ypos_player <= 715) ? 1 : 0, 1);
`ifdef PLAYER_VEL_OUT_EN
    check("xvel", int'(xvel_player), m_vx);
    check("yvel", int'(yvel_player), m_vy);
`endif
  endtask

  task automatic cyc(input bit mv, input int x, input int y, input bit tk);
    int nx, ny, ntx, nty, cx, cy;
    @(negedge clk_in);
    mouse_valid = mv;
    xpos_mouse  = x[11:0];
    ypos_mouse  = y[11:0];
    frame_tick  = tk;
    @(posedge clk_in);
    cx = clampi(x, 64, 491);
    cy = clampi(y, 64, 715);
    nx = m_x; ny = m_y;
    if (tk) begin
      if (m_mode == 1) begin
        nx = toward(m_x, m_tx);
        ny = toward(m_y, m_ty);
      end
      m_vx = nx - m_x;
      m_vy = ny - m_y;
    end
    ntx = mv ? cx : m_tx;
    nty = mv ? cy : m_ty;
    case (m_mode)
      0: if (mv) m_mode = 1;
      1: if (tk && nx == ntx && ny == nty) m_mode = 2;
      default: if (mv && (cx != m_x || cy != m_y)) m_mode = 1;
    endcase
    m_x = nx; m_y = ny; m_tx = ntx; m_ty = nty;
    #1;
    compare();
    mouse_valid = 1'b0;
    frame_tick  = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_x", int'(xpos_player), 150);
    check("rst_y", int'(ypos_player), 389);
    check("rst_moving", int'(moving), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic converge(input string tag, input int ex, input int ey);
    int n;
    n = 0;
    while (m_mode == 1 && n < 400) begin
      cyc(1'b0, 0, 0, 1'b1);
      n++;
    end
    check({tag, "_x"}, int'(xpos_player), ex);
    check({tag, "_y"}, int'(ypos_player), ey);
    check({tag, "_moving"}, int'(moving), 0);
  endtask

  initial begin
    model_reset();
    #12;
    #1;
    compare();
    @(negedge clk_in);
    rst_n = 1'b1;

    // idle paddle ignores ticks
    for (int i = 0; i < 10; i++) cyc(1'b0, 0, 0, 1'b1);
    check("t1_x", int'(xpos_player), 150);
    check("t1_y", int'(ypos_player), 389);

    // straight move to x=300
    cyc(1'b1, 300, 389, 1'b0);
    for (int k = 1; k <= 38; k++) begin
      cyc(1'b0, 0, 0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1);
      check("t2_x", int'(xpos_player), (k < 38) ? 150 + 4 * k : 300);
      check("t2_y", int'(ypos_player), 389);
      check("t2_moving", int'(moving), (k < 38) ? 1 : 0);
`ifdef PLAYER_VEL_OUT_EN
      check("t7_xvel", int'(xvel_player), (k < 38) ? 4 : 2);
`endif
    end
    cyc(1'b0, 0, 0, 1'b1);
    check("t2_hold_x", int'(xpos_player), 300);
`ifdef PLAYER_VEL_OUT_EN
    check("t7_xvel_zero", int'(xvel_player), 0);
`endif

    // out-of-range target clamps to the corner of player 1's half
    cyc(1'b1, 900, 10, 1'b0);
    converge("t3", 491, 64);

    // reset in the middle of a move
    do_reset();
    cyc(1'b1, 300, 389, 1'b0);
    while (m_x < 220) cyc(1'b0, 0, 0, 1'b1);
    check("t6_pre_x", int'(xpos_player), 222);
    do_reset();
    cyc(1'b0, 0, 0, 1'b1);
    check("t6_wait_x", int'(xpos_player), 150);

    // extreme raw samples must not wrap
    cyc(1'b1, 4095, 0, 1'b0);
    converge("t4", 491, 64);

    // simultaneous new target and tick: old target governs that step
    do_reset();
    cyc(1'b1, 300, 389, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b1);
    check("t5_pre", int'(xpos_player), 162);
    cyc(1'b1, 100, 389, 1'b1);
    check("t5_same", int'(xpos_player), 166);
    cyc(1'b0, 0, 0, 1'b1);
    check("t5_next", int'(xpos_player), 162);
    converge("t5", 100, 389);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit mv, tk;
      int rx, ry;
      mv = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rx = $urandom_range(0, 4095);
        ry = $urandom_range(0, 4095);
      end else begin
        rx = $urandom_range(40, 520);
        ry = $urandom_range(40, 740);
      end
      cyc(mv, rx, ry, tk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
